spm_loader: RTL and testbench
=============================

Name: spm_loader

Overview:
- Boot-time initiator for the SPM test port of pipeline_cpu_top (test_spm_addr/as_/rw/wr_data/rd_data).
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes the words to consecutive SPM word addresses, optionally reads the region back and checks an XOR checksum.
- On success, drives cpu_en high so the CPU takes ownership of the SPM ports and starts fetching.

Parameters:
- VERIFY_EN, 1, 1 = read-back checksum pass after the write pass; 0 = go straight to DONE.
- ADDR_W, 30, word-address width; matches WORD_ADDR_BUS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load; sampled only in IDLE, DONE or ERROR
- base_addr  in  ADDR_W  first SPM word address; captured on start
- word_cnt  in  ADDR_W  number of words to load; captured on start
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte
- test_spm_addr  out  ADDR_W  SPM word address
- test_spm_as_  out  1  SPM access strobe, active-low
- test_spm_rw  out  1  READ/WRITE constants from the shared define file
- test_spm_wr_data  out  32  SPM write data
- test_spm_rd_data  in  32  SPM read data; valid one cycle after a read strobe
- cpu_en  out  1  high = CPU owns the SPM
- busy  out  1  load in progress
- done  out  1  load completed and verified
- err  out  1  checksum mismatch

Behaviour:
- Reset values (asynchronous): state IDLE, in_ready=0, test_spm_as_=1, test_spm_rw=READ, test_spm_addr=0, test_spm_wr_data=0, cpu_en=0, busy=0, done=0, err=0, both checksums 0.
- A byte transfers on a clock edge where in_valid && in_ready.
- IDLE:
  - Outputs idle.
  - On start: capture base_addr and word_cnt, clear the checksums and err.
  - Go to DONE if word_cnt==0, otherwise go to RECV.
- RECV:
  - in_ready=1, busy=1.
  - Byte n of a word (n=0..3) goes to bits [8n+7:8n].
  - A 2-bit byte counter wraps at 4; after the 4th byte, go to WRITE.
  - No timeout: an idle stream holds the loader in RECV.
- WRITE (exactly one cycle):
  - in_ready=0, test_spm_as_=0, test_spm_rw=WRITE, test_spm_addr=cur_addr, test_spm_wr_data=word.
  - wr_sum ^= word.
  - cur_addr increments modulo 2^ADDR_W, so the address wraps from 0x3FFFFFFF to 0.
  - If more words remain, go to RECV; otherwise go to VERIFY (VERIFY_EN=1) or DONE.
- Minimum write throughput: 5 cycles per word.
- VERIFY:
  - One read issued per cycle: test_spm_as_=0, rw=READ, addresses base_addr .. base_addr+word_cnt-1 (mod 2^ADDR_W).
  - Read data arriving the following cycle is XORed into rd_sum. The pipeline is 1 deep, so the last data lands one cycle after the last issue (VERIFY_TAIL state, as_=1).
  - Then compare: equal goes to DONE; unequal goes to ERROR.
- DONE: cpu_en=1, done=1, busy=0, test_spm_as_=1, test_spm_wr_data=0. A new start clears cpu_en/done the same edge and restarts the load.
- ERROR: err=1, cpu_en=0. Held until a new start or reset.
- start while busy is ignored.
- in_valid while not in RECV: no effect; the byte is not consumed because in_ready=0.
- Reset mid-load: immediate return to reset values. Partial SPM contents are left undefined, and cpu_en stays low.
- All outputs are registered except in_ready, which is decoded from the state register. No combinational paths from inputs to outputs.

Decomposition:
- Shared package/define file:
  - State encoding (IDLE, RECV, WRITE, VERIFY, VERIFY_TAIL, DONE, ERROR).
  - Reuse the existing READ/WRITE, WORD_ADDR_BUS and WORD_WIDTH definitions.
- One natural sub-module: byte_packer. It holds the byte counter and shift/pack register, and emits a word_valid pulse after 4 accepted bytes. The FSM, address counter and checksums stay in spm_loader.

Test Plan:
- base=0x10, cnt=2, bytes 78 56 34 12 EF BE AD DE, VERIFY_EN=1, model SPM -> writes 0x12345678 @0x10 and 0xDEADBEEF @0x11; 2 reads; done=1, cpu_en=1, err=0.
- cnt=0 start -> DONE the next cycle; no strobe ever asserted; cpu_en=1.
- Model SPM corrupts the read of 0x11 to 0xDEADBEEE -> err=1, cpu_en=0, done=0; a following start with a good model reaches DONE.
- base=0x3FFFFFFF, cnt=2 -> writes at 0x3FFFFFFF then 0x00000000.
- in_valid toggled randomly with 0–3 idle gaps -> packing is unchanged, in_ready=0 on every WRITE cycle, no byte dropped or duplicated.
- reset asserted during RECV after 2 bytes -> outputs return to reset values immediately; a fresh start reloads correctly from byte 0.

Source files
------------

// File: rtl/spm_loader_pkg.sv
// Shared definitions for the SPM boot loader: bus widths, SPM access
// direction constants and the loader state encoding.
package spm_loader_pkg;

  localparam int WORD_ADDR_BUS = 30;
  localparam int WORD_WIDTH    = 32;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_VERIFY,
    ST_VERIFY_TAIL,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/spm_loader_byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words; word_valid
// pulses for one cycle once the 4th byte of a word has been shifted in.
module spm_loader_byte_packer
  import spm_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [7:0]            data,
  output logic                  last,
  output logic [WORD_WIDTH-1:0] word_nxt,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid
);

  logic [1:0] byte_cnt;

  // Shifting in from the top leaves byte 0 in [7:0] after four accepts.
  assign word_nxt = {data, word[WORD_WIDTH-1:8]};
  assign last     = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt   <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last;
      if (accept) begin
        word     <= word_nxt;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/spm_loader.sv
// Boot-time SPM loader: writes a packed byte stream to consecutive SPM words,
// optionally verifies it by XOR checksum, then hands the SPM to the CPU.
module spm_loader
  import spm_loader_pkg::*;
#(
  parameter bit VERIFY_EN = 1'b1,
  parameter int ADDR_W    = WORD_ADDR_BUS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     word_cnt,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     test_spm_addr,
  output logic                  test_spm_as_,
  output logic                  test_spm_rw,
  output logic [WORD_WIDTH-1:0] test_spm_wr_data,
  input  logic [WORD_WIDTH-1:0] test_spm_rd_data,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e                state, state_nxt;
  logic [ADDR_W-1:0]     base_q, cnt_q, cur_addr, words_left, vcnt;
  logic [WORD_WIDTH-1:0] wr_sum, rd_sum;
  logic                  rd_pend, start_ok;
  logic                  pk_last, pk_word_valid;
  logic [WORD_WIDTH-1:0] pk_word_nxt, pk_word;

  assign in_ready = (state == ST_RECV);
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

  spm_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (in_valid && in_ready),
    .data       (in_data),
    .last       (pk_last),
    .word_nxt   (pk_word_nxt),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (start) state_nxt = (word_cnt == '0) ? ST_DONE : ST_RECV;
      ST_RECV:
        if (pk_last) state_nxt = ST_WRITE;
      ST_WRITE:
        if (words_left == ADDR_W'(1)) state_nxt = VERIFY_EN ? ST_VERIFY : ST_DONE;
        else                          state_nxt = ST_RECV;
      ST_VERIFY:
        if (vcnt == '0) state_nxt = ST_VERIFY_TAIL;
      // The last read's data is on the bus this cycle, so fold it in here.
      ST_VERIFY_TAIL:
        state_nxt = ((rd_sum ^ test_spm_rd_data) == wr_sum) ? ST_DONE : ST_ERROR;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q           <= '0;
      cnt_q            <= '0;
      cur_addr         <= '0;
      words_left       <= '0;
      vcnt             <= '0;
      wr_sum           <= '0;
      rd_sum           <= '0;
      rd_pend          <= 1'b0;
      test_spm_addr    <= '0;
      test_spm_as_     <= 1'b1;
      test_spm_rw      <= READ;
      test_spm_wr_data <= '0;
      cpu_en           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      test_spm_as_ <= 1'b1;
      test_spm_rw  <= READ;
      rd_pend      <= (state == ST_VERIFY);
      if (rd_pend)       rd_sum <= rd_sum ^ test_spm_rd_data;
      if (pk_word_valid) wr_sum <= wr_sum ^ pk_word;

      // Strobe is registered on entry so it is live for the single WRITE cycle.
      if (state == ST_RECV && pk_last) begin
        test_spm_as_     <= 1'b0;
        test_spm_rw      <= WRITE;
        test_spm_addr    <= cur_addr;
        test_spm_wr_data <= pk_word_nxt;
      end
      if (state == ST_WRITE) begin
        cur_addr   <= cur_addr + ADDR_W'(1);
        words_left <= words_left - ADDR_W'(1);
      end
      if (state_nxt == ST_VERIFY) begin
        test_spm_as_ <= 1'b0;
        if (state == ST_WRITE) begin
          test_spm_addr <= base_q;
          vcnt          <= cnt_q - ADDR_W'(1);
        end else begin
          test_spm_addr <= test_spm_addr + ADDR_W'(1);
          vcnt          <= vcnt - ADDR_W'(1);
        end
      end
      if (state_nxt == ST_DONE) test_spm_wr_data <= '0;

      busy   <= (state_nxt == ST_RECV) || (state_nxt == ST_WRITE) ||
                (state_nxt == ST_VERIFY) || (state_nxt == ST_VERIFY_TAIL);
      done   <= (state_nxt == ST_DONE);
      cpu_en <= (state_nxt == ST_DONE);
      err    <= (state_nxt == ST_ERROR);

      if (start_ok) begin
        base_q     <= base_addr;
        cnt_q      <= word_cnt;
        cur_addr   <= base_addr;
        words_left <= word_cnt;
        wr_sum     <= '0;
        rd_sum     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spm_loader.sv
// Directed bench for spm_loader against a one-cycle-latency SPM model.
module tb_spm_loader;
  import spm_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [29:0] base_addr = '0, word_cnt = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [29:0] test_spm_addr;
  logic        test_spm_as_, test_spm_rw;
  logic [31:0] test_spm_wr_data;
  logic [31:0] test_spm_rd_data = '0;
  logic        cpu_en, busy, done, err;

  int vecs = 0, fails = 0;
  int strobes = 0, rdy_in_wr = 0;
  logic [29:0] wa[$], ra[$];
  logic [31:0] wd[$];
  logic [31:0] mem [logic [29:0]];
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic        corrupt_en = 1'b0;
  logic [29:0] corrupt_addr = '0;

  spm_loader #(.VERIFY_EN(1'b1), .ADDR_W(30)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .test_spm_addr(test_spm_addr),
    .test_spm_as_(test_spm_as_), .test_spm_rw(test_spm_rw),
    .test_spm_wr_data(test_spm_wr_data), .test_spm_rd_data(test_spm_rd_data),
    .cpu_en(cpu_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // SPM model: observe strobes mid-cycle, return read data just after the next edge.
  always @(negedge clk) begin
    pend = 1'b0;
    if (reset && !test_spm_as_) begin
      strobes++;
      if (test_spm_rw == WRITE) begin
        mem[test_spm_addr] = test_spm_wr_data;
        wa.push_back(test_spm_addr);
        wd.push_back(test_spm_wr_data);
        if (in_ready) rdy_in_wr++;
      end else begin
        ra.push_back(test_spm_addr);
        pend_data = mem.exists(test_spm_addr) ? mem[test_spm_addr] : 32'h0;
        if (corrupt_en && test_spm_addr == corrupt_addr) pend_data = pend_data ^ 32'h1;
        pend = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    test_spm_rd_data = pend ? pend_data : 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); ra.delete();
    strobes = 0; rdy_in_wr = 0;
  endtask

  task automatic start_load(input logic [29:0] b, input logic [29:0] c);
    @(negedge clk);
    start = 1'b1; base_addr = b; word_cnt = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("byte_accept_timeout", 64'(n == 100), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 300) begin @(negedge clk); n++; end
    check(tag, 64'(n == 300), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_as_", 64'(test_spm_as_), 64'd1);
    check("rst_rw", 64'(test_spm_rw), 64'(READ));
    check("rst_addr", 64'(test_spm_addr), 64'd0);
    check("rst_outs", {60'd0, cpu_en, busy, done, err}, 64'd0);
    reset = 1'b1;

    // Basic two-word load with verify
    clear_logs();
    start_load(30'h10, 30'd2);
    check("t1_busy", 64'(busy), 64'd1);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    wait_end("t1_timeout");
    check("t1_nwr", 64'(wa.size()), 64'd2);
    check("t1_wr0", {wa[0], wd[0]}, {30'h10, 32'h12345678});
    check("t1_wr1", {wa[1], wd[1]}, {30'h11, 32'hDEADBEEF});
    check("t1_nrd", 64'(ra.size()), 64'd2);
    check("t1_rd_addr", {ra[0], ra[1]}, {30'h10, 30'h11});
    check("t1_flags", {61'd0, done, cpu_en, err}, {61'd0, 3'b110});
    check("t1_busy_end", 64'(busy), 64'd0);

    // Zero-length load from DONE
    clear_logs();
    start_load(30'h40, 30'd0);
    check("t2_done", {62'd0, done, cpu_en}, 64'd3);
    repeat (3) @(negedge clk);
    check("t2_strobes", 64'(strobes), 64'd0);

    // Corrupted read-back -> ERROR, then a clean retry
    clear_logs();
    corrupt_en = 1'b1; corrupt_addr = 30'h11;
    start_load(30'h10, 30'd2);
    send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0);
    wait_end("t3_timeout");
    check("t3_flags", {61'd0, done, cpu_en, err}, 64'b001);
    repeat (2) @(negedge clk);
    check("t3_err_hold", 64'(err), 64'd1);
    corrupt_en = 1'b0;
    clear_logs();
    start_load(30'h10, 30'd2);
    check("t3_err_clr", 64'(err), 64'd0);
    send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0);
    wait_end("t3b_timeout");
    check("t3b_flags", {61'd0, done, cpu_en, err}, 64'b110);

    // Address wrap at the top of the word space
    clear_logs();
    start_load(30'h3FFFFFFF, 30'd2);
    send_word(32'hA5A5_0001, 0); send_word(32'h5A5A_0002, 0);
    wait_end("t4_timeout");
    check("t4_wr0", {wa[0], wd[0]}, {30'h3FFFFFFF, 32'hA5A50001});
    check("t4_wr1", {wa[1], wd[1]}, {30'h0, 32'h5A5A0002});
    check("t4_rd", {ra[0], ra[1]}, {30'h3FFFFFFF, 30'h0});
    check("t4_flags", {61'd0, done, cpu_en, err}, 64'b110);

    // Bursty stream with random idle gaps
    clear_logs();
    start_load(30'h200, 30'd3);
    send_word(32'h0403_0201, 3); send_word(32'hCAFE_F00D, 3); send_word(32'h8000_0001, 3);
    wait_end("t5_timeout");
    check("t5_nwr", 64'(wa.size()), 64'd3);
    check("t5_wd0", 64'(wd[0]), 64'h04030201);
    check("t5_wd1", 64'(wd[1]), 64'hCAFEF00D);
    check("t5_wd2", 64'(wd[2]), 64'h80000001);
    check("t5_wa2", 64'(wa[2]), 64'h202);
    check("t5_rdy_in_wr", 64'(rdy_in_wr), 64'd0);
    check("t5_flags", {61'd0, done, cpu_en, err}, 64'b110);

    // Reset mid-word, then a fresh load from byte 0
    clear_logs();
    start_load(30'h20, 30'd1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_ready", 64'(in_ready), 64'd0);
    check("t6_rst_outs", {60'd0, cpu_en, busy, done, err}, 64'd0);
    check("t6_rst_as_", 64'(test_spm_as_), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    start_load(30'h20, 30'd1);
    send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
    wait_end("t6_timeout");
    check("t6_wr", {wa[0], wd[0]}, {30'h20, 32'h11223344});
    check("t6_flags", {61'd0, done, cpu_en, err}, 64'b110);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
